// File: rtl/mcycle_controller.sv
// mcycle_controller: multi-cycle control FSM for the 16-bit datapath.
// Each instruction starts in FETCH and ends with exactly one pcEn pulse.
// The FSM then returns to FETCH.
// Control outputs are decoded from the current state, the latched
// instruction and capturedPSR. Outputs are forced low while reset is high,
// so an instruction interrupted by reset never commits a write.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to make illegal
// instructions trap to PC 0. Without it, illegal instructions execute as NOP.

module mcycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [7:0]  capturedPSR,
  input  logic        aluOutIsZero,
  output logic        pcEn,
  output logic        instrWrite,
  output logic        regWrite,
  output logic        writeBackSelect,
  output logic        dataToWriteSelect,
  output logic        newAluInput,
  output logic        psrRegEn,
  output logic        memWrite,
  output logic        trap,
  output logic [1:0]  aluSrc1Select,
  output logic [1:0]  aluSrc2Select,
  output logic [1:0]  pcSrc,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC     = 4'd2,
    WB       = 4'd3,
    LD_MEM   = 4'd4,
    LD_SEL   = 4'd5,
    LD_WB    = 4'd6,
    ST       = 4'd7,
    JAL_LINK = 4'd8,
    JUMP     = 4'd9,
    BRANCH   = 4'd10,
`ifdef CTRL_ILLEGAL_TRAP_EN
    ADV      = 4'd11,
    TRAP     = 4'd12
`else
    ADV      = 4'd11
`endif
  } ctrlStateT;

  ctrlStateT currentState;
  logic      jalPending;

  logic [3:0] opcode;
  logic [3:0] ext;
  logic [3:0] cond;
  logic       isRAlu;
  logic       isIAlu;
  logic       isCmp;
  logic       isLoad;
  logic       isStor;
  logic       isJal;
  logic       isJcond;
  logic       isBcond;
  logic       isNop;
  logic       condTrue;
  logic       takeJump;

  logic flagN;
  logic flagZ;
  logic flagF;
  logic flagL;
  logic flagC;

  // The zero flag from the ALU and the unassigned PSR bits are not used by the control logic.
  logic unusedBits;
  assign unusedBits = aluOutIsZero ^ capturedPSR[4] ^ capturedPSR[3] ^ capturedPSR[1];

  assign opcode = instr[15:12];
  assign ext    = instr[7:4];
  assign cond   = instr[11:8];

  assign flagN = capturedPSR[7];
  assign flagZ = capturedPSR[6];
  assign flagF = capturedPSR[5];
  assign flagL = capturedPSR[2];
  assign flagC = capturedPSR[0];

  assign isRAlu  = (opcode == 4'b0000) &&
                   (ext inside {4'b0001, 4'b0010, 4'b0011, 4'b0101,
                                4'b1001, 4'b1011, 4'b1101});
  assign isIAlu  = opcode inside {4'b0001, 4'b0010, 4'b0011, 4'b0101,
                                  4'b1001, 4'b1011, 4'b1101, 4'b1111};
  assign isCmp   = (isRAlu && (ext == 4'b1011)) || (opcode == 4'b1011);
  assign isLoad  = (opcode == 4'b0100) && (ext == 4'b0000);
  assign isStor  = (opcode == 4'b0100) && (ext == 4'b0100);
  assign isJal   = (opcode == 4'b0100) && (ext == 4'b1000);
  assign isJcond = (opcode == 4'b0100) && (ext == 4'b1100);
  assign isBcond = (opcode == 4'b1100);
  assign isNop   = (instr == 16'h0000);

  // Evaluate the branch/jump condition from the flags present this cycle.
  always_comb begin
    condTrue = 1'b0;
    case (cond)
      4'b0000: condTrue = flagZ;
      4'b0001: condTrue = ~flagZ;
      4'b0010: condTrue = flagC;
      4'b0011: condTrue = ~flagC;
      4'b0100: condTrue = flagL;
      4'b0101: condTrue = ~flagL;
      4'b0110: condTrue = flagN;
      4'b0111: condTrue = ~flagN;
      4'b1000: condTrue = flagF;
      4'b1001: condTrue = ~flagF;
      4'b1010: condTrue = ~flagL & ~flagZ;
      4'b1011: condTrue = flagL | flagZ;
      4'b1100: condTrue = ~flagN & ~flagZ;
      4'b1101: condTrue = flagN | flagZ;
      4'b1110: condTrue = 1'b1;
      default: condTrue = 1'b0;
    endcase
  end

  // A JAL reaches JUMP with its condition forced true; its cond field holds a register number.
  assign takeJump = jalPending | condTrue;

  // Advance the instruction sequence and remember when JUMP was entered from JAL_LINK.
  always_ff @(posedge clk) begin
    if (reset) begin
      currentState <= FETCH;
      jalPending   <= 1'b0;
    end else begin
      case (currentState)
        FETCH: begin
          currentState <= DECODE;
          jalPending   <= 1'b0;
        end
        DECODE: begin
          if (isRAlu || isIAlu)  currentState <= EXEC;
          else if (isLoad)       currentState <= LD_MEM;
          else if (isStor)       currentState <= ST;
          else if (isJal)        currentState <= JAL_LINK;
          else if (isJcond)      currentState <= JUMP;
          else if (isBcond)      currentState <= BRANCH;
          else if (isNop)        currentState <= ADV;
`ifdef CTRL_ILLEGAL_TRAP_EN
          else                   currentState <= TRAP;
`else
          else                   currentState <= ADV;
`endif
        end
        EXEC:     currentState <= WB;
        WB:       currentState <= FETCH;
        LD_MEM:   currentState <= LD_SEL;
        LD_SEL:   currentState <= LD_WB;
        LD_WB:    currentState <= FETCH;
        ST:       currentState <= FETCH;
        JAL_LINK: begin
          currentState <= JUMP;
          jalPending   <= 1'b1;
        end
        JUMP: begin
          currentState <= FETCH;
          jalPending   <= 1'b0;
        end
        BRANCH:   currentState <= FETCH;
        ADV:      currentState <= FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
        TRAP:     currentState <= FETCH;
`endif
        default: begin
          currentState <= FETCH;
          jalPending   <= 1'b0;
        end
      endcase
    end
  end

  // Decode the control outputs for the current state; reset suppresses every output.
  always_comb begin
    pcEn              = 1'b0;
    instrWrite        = 1'b0;
    regWrite          = 1'b0;
    writeBackSelect   = 1'b0;
    dataToWriteSelect = 1'b0;
    newAluInput       = 1'b0;
    psrRegEn          = 1'b0;
    memWrite          = 1'b0;
    trap              = 1'b0;
    aluSrc1Select     = 2'b00;
    aluSrc2Select     = 2'b00;
    pcSrc             = 2'b00;
    if (!reset) begin
      case (currentState)
        FETCH:  instrWrite  = 1'b1;
        DECODE: newAluInput = 1'b1;
        EXEC: begin
          aluSrc1Select = 2'b01;
          aluSrc2Select = isIAlu ? 2'b01 : 2'b00;
          psrRegEn      = 1'b1;
        end
        WB: begin
          aluSrc1Select = 2'b01;
          aluSrc2Select = isIAlu ? 2'b01 : 2'b00;
          regWrite      = ~isCmp;
          pcEn          = 1'b1;
        end
        LD_MEM: begin
        end
        LD_SEL: writeBackSelect = 1'b1;
        LD_WB: begin
          writeBackSelect = 1'b1;
          regWrite        = 1'b1;
          pcEn            = 1'b1;
        end
        ST: begin
          memWrite = 1'b1;
          pcEn     = 1'b1;
        end
        JAL_LINK: begin
          regWrite          = 1'b1;
          dataToWriteSelect = 1'b1;
        end
        JUMP: begin
          pcEn  = 1'b1;
          pcSrc = takeJump ? 2'b01 : 2'b00;
        end
        BRANCH: begin
          pcEn  = 1'b1;
          pcSrc = condTrue ? 2'b10 : 2'b00;
        end
        ADV: pcEn = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        TRAP: begin
          trap  = 1'b1;
          pcEn  = 1'b1;
          pcSrc = 2'b11;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign state = currentState;

endmodule

// File: doc/mcycle_controller.md
MCYCLE_CONTROLLER -- requirements
Module: mcycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 The block SHALL have these inputs: instr  input  16  latched instruction; capturedPSR  input  8  flags {N[7],Z[6],F[5],L[2],C[0]}; aluOutIsZero  input  1  unused by control, reserved.
REQ-003 The block SHALL drive these 1-bit outputs: pcEn, instrWrite, regWrite, writeBackSelect, dataToWriteSelect, newAluInput, psrRegEn, memWrite, trap.
REQ-004 The block SHALL drive these 2-bit outputs: aluSrc1Select, aluSrc2Select, pcSrc. It SHALL also drive state  output  4  current FSM state for debug.

Function
REQ-005 The block SHALL be a Moore-style FSM; outputs decode from state, instr and capturedPSR only; any output not listed for a state is 0.
REQ-006 Decode: opcode=instr[15:12], ext=instr[7:4], cond=instr[11:8].
REQ-007 Decode: R-ALU = opcode 0000 with ext in {0001,0010,0011,0101,1001,1011,1101}.
REQ-008 Decode: I-ALU = opcode in {0001,0010,0011,0101,1001,1011,1101,1111}.
REQ-009 Decode: CMP = (R-ALU and ext 1011) or opcode 1011.
REQ-010 Decode: opcode 0100 with ext 0000 = LOAD, 0100 = STOR, 1000 = JAL, 1100 = Jcond; opcode 1100 = Bcond.
REQ-011 Decode: NOP = 0x0000. Everything else is ILLEGAL.
REQ-012 FETCH SHALL assert instrWrite=1 and go to DECODE.
REQ-013 DECODE SHALL assert newAluInput=1 and branch on class: R/I-ALU->EXEC; LOAD->LD_MEM; STOR->ST; JAL->JAL_LINK; Jcond->JUMP; Bcond->BRANCH; NOP->ADV; ILLEGAL->TRAP (or ADV, see REQ-026).
REQ-014 EXEC SHALL assert aluSrc1Select=01, aluSrc2Select=00 for R-ALU or 01 for I-ALU, and psrRegEn=1, then go to WB.
REQ-015 WB SHALL assert aluSrc selects as in EXEC, regWrite=~CMP, writeBackSelect=0, dataToWriteSelect=0, pcEn=1, pcSrc=00, then go to FETCH.
REQ-016 LOAD SHALL use a 3-cycle tail: LD_MEM (no control, MDR captures) -> LD_SEL (writeBackSelect=1) -> LD_WB (writeBackSelect=1, regWrite=1, pcEn=1, pcSrc=00) -> FETCH.
REQ-017 ST SHALL assert memWrite=1 for exactly one cycle plus pcEn=1, pcSrc=00, then go to FETCH.
REQ-018 JAL_LINK SHALL assert regWrite=1, dataToWriteSelect=1 (link = current PC), then go to JUMP with cond forced true; the target is the B latch captured in DECODE, so Rdest==Rsrc is well defined.
REQ-019 Condition truth table for cond: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 L; 0101 !L; 0110 N; 0111 !N; 1000 F; 1001 !F; 1010 !L&!Z; 1011 L|Z; 1100 !N&!Z; 1101 N|Z; 1110 1; 1111 0.
REQ-020 JUMP SHALL assert pcEn=1 and pcSrc=01 if the condition is true, else 00, then go to FETCH.
REQ-021 BRANCH SHALL assert pcEn=1 and pcSrc=10 if the condition is true, else 00, then go to FETCH.
REQ-022 ADV SHALL assert pcEn=1, pcSrc=00, then go to FETCH.
REQ-023 Conditions SHALL be evaluated from capturedPSR as sampled in the JUMP/BRANCH cycle.
REQ-024 Latency in cycles: ALU 4, STOR 3, LOAD 5, Jcond/Bcond/NOP 3, JAL 4; exactly one pcEn pulse per instruction.
REQ-025 Undefined state encodings SHALL transition to FETCH with all outputs 0.

Configuration
REQ-026 With macro CTRL_ILLEGAL_TRAP_EN defined, ILLEGAL SHALL go DECODE->TRAP; TRAP asserts trap=1, pcEn=1, pcSrc=11 (PC<=0) for one cycle, then goes to FETCH.
REQ-027 Without CTRL_ILLEGAL_TRAP_EN, ILLEGAL SHALL go to ADV (executes as NOP), trap SHALL be tied 0, and TRAP SHALL not exist.

Reset
REQ-028 While reset=1 all control outputs SHALL be 0 and state SHALL load FETCH at the clock edge.
REQ-029 Reset asserted in any state, including mid-LOAD or on a ST cycle, SHALL abort the instruction with no regWrite/memWrite/pcEn in that cycle.
REQ-030 The first FETCH SHALL occur in the first cycle after reset deasserts.

Verification
REQ-031 Reset, then ADD 0x0152 -> states FETCH,DECODE,EXEC,WB; regWrite=1 only in WB; exactly one pcEn pulse (pcSrc=00).
REQ-032 CMPI 0xB305 -> psrRegEn=1 in EXEC; regWrite=0 throughout; pcEn in WB.
REQ-033 LOAD 0x4203 -> LD_MEM,LD_SEL,LD_WB; writeBackSelect=1 in LD_SEL and LD_WB; regWrite only in LD_WB; total 5 cycles.
REQ-034 Bcond 0xC0FE with capturedPSR[6]=1 -> pcSrc=10; with capturedPSR[6]=0 -> pcSrc=00. Jcond cond=1111 -> pcSrc=00 always.
REQ-035 Opcode 0x7000 -> with CTRL_ILLEGAL_TRAP_EN: trap=1, pcSrc=11 for one cycle; without it: trap=0, pcSrc=00. Separately, reset pulsed during ST -> memWrite=0 in that cycle, state=FETCH next.
